alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream control stage of the 3-bit ALU. Samples switch operands and op_code on a start press.
//  Holds them stable on the ALU operand/op_code inputs.
//  Issues the ALU's load1 -> load2 -> run strobe sequence with fixed pulse widths and gaps.
//  Reports busy/done to the front panel.
// PARAMETERS
//  WIDTH    3  operand width (ALU data path width)
//  PULSE_W  2  cycles each of load1/load2/run is held high (>=1)
//  GAP_W    1  low cycles between consecutive strobes (>=1)
// PORTS
//  clk       in   1      system clock; all state changes on rising edge
//  rst       in   1      synchronous, active-high reset
//  sw_a      in   WIDTH  operand 1 switches
//  sw_b      in   WIDTH  operand 2 switches
//  sw_op     in   4      op_code switches
//  start     in   1      start button level (synchronous, already debounced)
//  operand1  out  WIDTH  registered operand 1 to ALU
//  operand2  out  WIDTH  registered operand 2 to ALU
//  op_code   out  4      registered op_code to ALU
//  load1     out  1      ALU operand-1 register strobe
//  load2     out  1      ALU operand-2 register strobe
//  run       out  1      ALU result register strobe
//  busy      out  1      high from capture through DONE
//  done      out  1      one-cycle pulse, sequence complete
//  err       out  1      one-cycle pulse, rejected opcode (ALU_OPCODE_CHECK_EN only)
// BEHAVIOUR
//  - Reset (sync, rst=1 at clk edge):
//    - state=IDLE; all outputs 0, including operand1/operand2/op_code; start history cleared.
//    - Reset mid-sequence aborts immediately; a strobe in progress drops low on the next cycle.
//  - start_q registers start; start_edge = start & ~start_q.
//  - Only edges seen in IDLE are acted on. Edges during busy are discarded, never queued.
//  - A held start yields exactly one command.
//  - FSM (registered outputs; all strobes glitch-free):
//    - IDLE: on start_edge, capture sw_a/sw_b/sw_op into operand1/operand2/op_code -> SETUP.
//    - SETUP (1 cyc): busy=1, strobes low. Operands settle ahead of the load1 rising edge -> LD1.
//    - LD1 (PULSE_W) load1=1 -> G1 (GAP_W) -> LD2 (PULSE_W) load2=1 -> G2 (GAP_W).
//    - RUN (PULSE_W) run=1 -> DONE.
//    - DONE (1 cyc): done=1, busy=1 -> IDLE.
//  - At most one strobe is high in any cycle. load1/load2/run are never high together.
//  - Latency: start_edge sample to done = 2 + 3*PULSE_W + 2*GAP_W cycles (defaults: 10).
//  - operand1/operand2/op_code hold their captured values from capture until the next accepted capture.
//    - The ALU's load1-clocked shift path sees a stable operand1 through the entire strobe.
//  - A 0 -> 1 -> 0 pulse of each strobe is exactly PULSE_W cycles high.
//  - Pulse counter is $clog2(max(PULSE_W,GAP_W))+1 bits. It reloads on every state entry and never wraps.
// CONFIGURATION
//  - ALU_OPCODE_CHECK_EN defined:
//    - In IDLE, a start_edge with sw_op > 4'b1010 is rejected.
//    - No capture, no strobes, busy stays 0, err=1 for one cycle; operand/op_code outputs unchanged.
//  - Not defined: err tied 0; every sw_op value 0..15 is sequenced normally.
// STRUCTURE
//  - Shared package alu_pkg:
//    - op_code localparams OP_ADD=4'b0000 .. OP_SHR1=4'b1010 and OP_MAX=4'b1010.
//    - State enum IDLE/SETUP/LD1/G1/LD2/G2/RUN/DONE.
//  - One sub-module, alu_strobe_timer: loadable down-counter.
//    - Inputs: clk, rst, load, value. Output: expire.
//    - The FSM uses it for every PULSE_W/GAP_W interval.
// TESTING
//  - Reset, then sw_a=5, sw_b=3, sw_op=0001, start 0->1.
//    - operand1=101, operand2=011, op_code=0001 one cycle after edge.
//    - load1 high cycles 2-3, load2 high 5-6, run high 8-9, done pulse at cycle 10.
//  - Start held high 30 cycles -> exactly one done pulse; second press after done -> second full sequence.
//  - Second start edge while busy (cycle 4), sw_a changed to 2 -> ignored.
//    - operand1 stays 101 and a single done pulse occurs.
//  - rst asserted during LD2 -> next cycle all strobes/busy 0 and operands 0.
//    - A new start then gives a clean full sequence.
//  - With ALU_OPCODE_CHECK_EN, sw_op=1100 + start -> err=1 one cycle, no strobes, op_code unchanged.
//    - Without the macro: full sequence, op_code=1100.
//  - Integration with ALU: A=5, B=3, op 0001 -> C=110; op 1010 -> C=010.
//    - A=4, B=1, op 0001 -> C=101.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 3-bit ALU command path: op_code limits and the
// sequencer state encoding.
package alu_pkg;

    // First and last op_codes implemented by the ALU; anything above OP_MAX is undefined
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SHR1 = 4'b1010;
    localparam logic [3:0] OP_MAX  = 4'b1010;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LD1   = 3'd2,
        G1    = 3'd3,
        LD2   = 3'd4,
        G2    = 3'd5,
        RUN   = 3'd6,
        DONE  = 3'd7
    } seq_state_t;

endpackage

// File: rtl/alu_strobe_timer.sv
// Loadable saturating down-counter that times strobe pulses and gaps.
// Loading N makes expire rise N cycles later; the count stops at zero.
module alu_strobe_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          expire
);

    logic [CW-1:0] cnt_r;

    // Reload on request, otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= value;
        end else if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Front-panel command sequencer for the 3-bit ALU: captures switch operands on
// a start press and issues load1 -> load2 -> run strobes with fixed timing.
// Optional build macro ALU_OPCODE_CHECK_EN rejects op_codes above OP_MAX with
// a one-cycle err pulse; without it err is constant 0.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_a,
    input  logic [WIDTH-1:0] sw_b,
    input  logic [3:0]       sw_op,
    input  logic             start,
    output logic [WIDTH-1:0] operand1,
    output logic [WIDTH-1:0] operand2,
    output logic [3:0]       op_code,
    output logic             load1,
    output logic             load2,
    output logic             run,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW    = $clog2(MAX_W) + 1;
    // Timer counts down to zero, so a state lasting N cycles loads N-1
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);

    seq_state_t    state_r;
    seq_state_t    state_next_s;
    logic          start_q_r;
    logic          start_edge_s;
    logic          capture_s;
    logic          err_next_s;
    logic          timer_load_s;
    logic [CW-1:0] timer_value_s;
    logic          timer_expire_s;

    logic [WIDTH-1:0] operand1_r;
    logic [WIDTH-1:0] operand2_r;
    logic [3:0]       op_code_r;
    logic             load1_r;
    logic             load2_r;
    logic             run_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    assign start_edge_s = start & ~start_q_r;

    alu_strobe_timer #(
        .CW (CW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load_s),
        .value  (timer_value_s),
        .expire (timer_expire_s)
    );

    // Start history and state register
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q_r <= 1'b0;
            state_r   <= IDLE;
        end else begin
            start_q_r <= start;
            state_r   <= state_next_s;
        end
    end

    // Next-state decode, capture/reject decision and timer reload on state entry
    always_comb begin
        state_next_s  = state_r;
        capture_s     = 1'b0;
        err_next_s    = 1'b0;
        timer_load_s  = 1'b0;
        timer_value_s = {CW{1'b0}};
        case (state_r)
            IDLE: begin
                if (start_edge_s) begin
`ifdef ALU_OPCODE_CHECK_EN
                    if (sw_op > OP_MAX) begin
                        err_next_s = 1'b1;
                    end else begin
                        capture_s    = 1'b1;
                        state_next_s = SETUP;
                    end
`else
                    capture_s    = 1'b1;
                    state_next_s = SETUP;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETUP:   state_next_s = LD1;
            LD1:     state_next_s = timer_expire_s ? G1   : LD1;
            G1:      state_next_s = timer_expire_s ? LD2  : G1;
            LD2:     state_next_s = timer_expire_s ? G2   : LD2;
            G2:      state_next_s = timer_expire_s ? RUN  : G2;
            RUN:     state_next_s = timer_expire_s ? DONE : RUN;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase

        // Adjacent states always differ, so any change of state is an entry
        if (state_next_s != state_r) begin
            timer_load_s = 1'b1;
        end else begin
            timer_load_s = 1'b0;
        end
        case (state_next_s)
            LD1, LD2, RUN: timer_value_s = PULSE_LD;
            G1, G2:        timer_value_s = GAP_LD;
            default:       timer_value_s = {CW{1'b0}};
        endcase
    end

    // Operand/op_code holding registers, updated only on an accepted capture
    always_ff @(posedge clk) begin
        if (rst) begin
            operand1_r <= {WIDTH{1'b0}};
            operand2_r <= {WIDTH{1'b0}};
            op_code_r  <= 4'b0000;
        end else if (capture_s) begin
            operand1_r <= sw_a;
            operand2_r <= sw_b;
            op_code_r  <= sw_op;
        end else begin
            operand1_r <= operand1_r;
            operand2_r <= operand2_r;
            op_code_r  <= op_code_r;
        end
    end

    // Strobes and status registered from the next state so they track the state exactly and glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            load1_r <= 1'b0;
            load2_r <= 1'b0;
            run_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            load1_r <= (state_next_s == LD1);
            load2_r <= (state_next_s == LD2);
            run_r   <= (state_next_s == RUN);
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
            err_r   <= err_next_s;
        end
    end

    assign operand1 = operand1_r;
    assign operand2 = operand2_r;
    assign op_code  = op_code_r;
    assign load1    = load1_r;
    assign load2    = load2_r;
    assign run      = run_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer (default parameters:
// PULSE_W=2, GAP_W=1, so done arrives 10 cycles after the start edge).
module tb_alu_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] sw_a;
    logic [2:0] sw_b;
    logic [3:0] sw_op;
    logic       start;
    logic [2:0] operand1;
    logic [2:0] operand2;
    logic [3:0] op_code;
    logic       load1;
    logic       load2;
    logic       run;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .sw_a     (sw_a),
        .sw_b     (sw_b),
        .sw_op    (sw_op),
        .start    (start),
        .operand1 (operand1),
        .operand2 (operand2),
        .op_code  (op_code),
        .load1    (load1),
        .load2    (load2),
        .run      (run),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_load1"}, int'(load1), 0);
        chk({tag, "_load2"}, int'(load2), 0);
        chk({tag, "_run"},   int'(run),   0);
        chk({tag, "_busy"},  int'(busy),  0);
        chk({tag, "_done"},  int'(done),  0);
        chk({tag, "_err"},   int'(err),   0);
        chk({tag, "_op1"},   int'(operand1), 0);
        chk({tag, "_op2"},   int'(operand2), 0);
        chk({tag, "_opc"},   int'(op_code),  0);
    endtask

    // One full press: start low for a cycle, then rising edge sampled at cycle 0.
    // Checks cycles 1..12 against the hand-written timing table.
    // repress: drop start after cycle 2, raise it again with sw_a=2 so the edge lands at cycle 4.
    task automatic check_seq(input string tag, input logic [2:0] a, input logic [2:0] b,
                             input logic [3:0] op, input bit repress);
        int done_cnt;
        done_cnt = 0;
        start = 1'b0;
        tick();
        sw_a  = a;
        sw_b  = b;
        sw_op = op;
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk({tag, "_busy"},  int'(busy),  (k >= 1 && k <= 10) ? 1 : 0);
            chk({tag, "_load1"}, int'(load1), (k == 2 || k == 3) ? 1 : 0);
            chk({tag, "_load2"}, int'(load2), (k == 5 || k == 6) ? 1 : 0);
            chk({tag, "_run"},   int'(run),   (k == 8 || k == 9) ? 1 : 0);
            chk({tag, "_done"},  int'(done),  (k == 10) ? 1 : 0);
            chk({tag, "_err"},   int'(err),   0);
            chk({tag, "_op1"},   int'(operand1), int'(a));
            chk({tag, "_op2"},   int'(operand2), int'(b));
            chk({tag, "_opc"},   int'(op_code),  int'(op));
            if (done) done_cnt++;
            if (repress && k == 2) start = 1'b0;
            if (repress && k == 3) begin
                start = 1'b1;
                sw_a  = 3'd2;
            end
        end
        chk({tag, "_done_count"}, done_cnt, 1);
    endtask

    initial begin
        int extra_done;
        rst   = 1'b1;
        sw_a  = 3'd0;
        sw_b  = 3'd0;
        sw_op = 4'b0000;
        start = 1'b0;
        repeat (3) tick();
        chk_idle_zero("reset");
        rst = 1'b0;
        tick();
        chk_idle_zero("post_reset");

        // Basic sequence 5,3,0001; start then held high for 30 cycles total
        check_seq("seq1", 3'd5, 3'd3, 4'b0001, 1'b0);
        extra_done = 0;
        for (int k = 13; k <= 30; k++) begin
            tick();
            if (done || busy || load1 || load2 || run) extra_done++;
        end
        chk("held_start_no_retrigger", extra_done, 0);

        // Second press after done gives a second full sequence
        check_seq("seq2", 3'd4, 3'd1, 4'b1010, 1'b0);

        // Second edge while busy is discarded; operand1 must stay 5
        check_seq("busy_edge", 3'd5, 3'd3, 4'b0001, 1'b1);
        start = 1'b0;
        repeat (3) tick();
        chk("busy_edge_no_queue_busy", int'(busy), 0);
        chk("busy_edge_op1_hold", int'(operand1), 5);

        // Reset during LD2 aborts at once
        sw_a  = 3'd6;
        sw_b  = 3'd2;
        sw_op = 4'b0011;
        start = 1'b1;
        repeat (5) tick();
        chk("pre_abort_load2", int'(load2), 1);
        chk("pre_abort_op1", int'(operand1), 6);
        rst   = 1'b1;
        start = 1'b0;
        tick();
        chk_idle_zero("abort");
        rst = 1'b0;
        check_seq("after_abort", 3'd5, 3'd3, 4'b0001, 1'b0);

        // Out-of-range op_code 1100
`ifdef ALU_OPCODE_CHECK_EN
        start = 1'b0;
        tick();
        sw_a  = 3'd7;
        sw_op = 4'b1100;
        start = 1'b1;
        tick();
        chk("reject_err", int'(err), 1);
        chk("reject_busy", int'(busy), 0);
        chk("reject_opc", int'(op_code), 1);
        chk("reject_op1", int'(operand1), 5);
        for (int k = 2; k <= 12; k++) begin
            tick();
            chk("reject_err_low", int'(err), 0);
            chk("reject_no_strobe", int'(load1 | load2 | run | busy | done), 0);
        end
        chk("reject_opc_final", int'(op_code), 1);
`else
        check_seq("op1100", 3'd7, 3'd3, 4'b1100, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
